// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: NOP encoding, default reset PC and the
// fetch-stage FSM state encoding.
package pipeline_defs;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage
// (master) and instruction memory (slave).
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_rdy, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous reset, flush to a NOP bubble with the
// PC left untouched, otherwise load on write-enable or hold.
module if_id_reg
    import pipeline_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    // Pipeline register update; flush takes priority over the write-enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_pc    <= 32'h0000_0000;
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (i_we) begin
            o_pc    <= i_pc;
            o_instr <= i_instr;
            o_valid <= i_valid;
        end else begin
            o_pc    <= o_pc;
            o_instr <= o_instr;
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, absorbs
// stalls with a one-entry buffer and handles EX redirects, feeding IF/ID.
module if_stage
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PC_we,
    input  logic               IF_ID_we,
    input  logic               EX_redirect,
    input  logic [31:0]        EX_target,
    if_stage_if.master         imem,
    output logic [31:0]        IF_ID_pc,
    output logic [31:0]        IF_ID_instr,
    output logic               IF_ID_valid,
    output logic               fetch_wait
);

    if_state_e   r_state, w_next_state;
    logic [31:0] r_pc, w_next_pc;
    logic [31:0] r_redir_pc, w_next_redir_pc;
    logic [31:0] r_buf, w_next_buf;

    logic        w_advance;
    logic        w_id_we, w_id_flush, w_id_valid;
    logic [31:0] w_id_pc, w_id_instr;

    // Disagreeing stall controls are treated as a stall.
    assign w_advance = PC_we & IF_ID_we;

    // State and fetch-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_redir_pc <= 32'h0000_0000;
            r_buf      <= 32'h0000_0000;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_redir_pc <= w_next_redir_pc;
            r_buf      <= w_next_buf;
        end
    end

    // Next-state, next-PC and IF/ID control decode.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_redir_pc = r_redir_pc;
        w_next_buf      = r_buf;
        w_id_we         = 1'b0;
        w_id_flush      = 1'b0;
        w_id_pc         = IF_ID_pc;
        w_id_instr      = NOP_INSTR;
        w_id_valid      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (EX_redirect) begin
                    w_id_flush = 1'b1;
                    if (imem.imem_rdy) begin
                        w_next_pc = EX_target;
                    end else begin
                        w_next_redir_pc = EX_target;
                        w_next_state    = ST_DRAIN;
                    end
                end else if (imem.imem_rdy) begin
                    if (w_advance) begin
                        w_id_we    = 1'b1;
                        w_id_pc    = r_pc;
                        w_id_instr = imem.imem_rdata;
                        w_id_valid = 1'b1;
                        w_next_pc  = pc_plus4(r_pc);
                    end else begin
                        w_next_buf   = imem.imem_rdata;
                        w_next_state = ST_HOLD;
                    end
                end else begin
                    w_id_we = w_advance;
                end
            end
            ST_HOLD: begin
                if (EX_redirect) begin
                    w_id_flush   = 1'b1;
                    w_next_pc    = EX_target;
                    w_next_state = ST_FETCH;
                end else if (w_advance) begin
                    w_id_we      = 1'b1;
                    w_id_pc      = r_pc;
                    w_id_instr   = r_buf;
                    w_id_valid   = 1'b1;
                    w_next_pc    = pc_plus4(r_pc);
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                // Address stays at the wrong-path PC until memory answers.
                if (EX_redirect) begin
                    w_id_flush = 1'b1;
                    if (imem.imem_rdy) begin
                        w_next_pc    = EX_target;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_redir_pc = EX_target;
                    end
                end else begin
                    w_id_we = w_advance;
                    if (imem.imem_rdy) begin
                        w_next_pc    = r_redir_pc;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    assign imem.imem_req  = !rst && (r_state != ST_HOLD);
    assign imem.imem_addr = r_pc;
    assign fetch_wait     = rst || !((r_state == ST_HOLD) ||
                                     ((r_state == ST_FETCH) && imem.imem_rdy));

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_id_we),
        .i_flush (w_id_flush),
        .i_pc    (w_id_pc),
        .i_instr (w_id_instr),
        .i_valid (w_id_valid),
        .o_pc    (IF_ID_pc),
        .o_instr (IF_ID_instr),
        .o_valid (IF_ID_valid)
    );

endmodule
